// File: rtl/pipe_flush_ctrl_if.sv
// Pipeline-to-front-end control bundle for pipe_flush_ctrl.
// master = pipeline/CP0 side (drives requests), slave = the flush controller.
interface pipe_flush_ctrl_if #(
    parameter int NSTAGE = 4,
    parameter int ADDR_W = 32
);
    logic [NSTAGE-1:0] stallreq;
    logic              br_mispredict;
    logic [ADDR_W-1:0] br_target;
    logic              exception_flag;
    logic [4:0]        exception_type;
    logic [ADDR_W-1:0] cp0_epc_i;
    logic [ADDR_W-1:0] ebase_i;

    logic [NSTAGE-1:0] stall;
    logic              flush;
    logic              flush_cause;
    logic [ADDR_W-1:0] epc_o;
    logic              flush_to_ibuffer;
    logic              br_pending;

    modport master (
        output stallreq, br_mispredict, br_target, exception_flag, exception_type,
               cp0_epc_i, ebase_i,
        input  stall, flush, flush_cause, epc_o, flush_to_ibuffer, br_pending
    );

    modport slave (
        input  stallreq, br_mispredict, br_target, exception_flag, exception_type,
               cp0_epc_i, ebase_i,
        output stall, flush, flush_cause, epc_o, flush_to_ibuffer, br_pending
    );
endinterface

// File: rtl/pipe_flush_ctrl.sv
// Stall/flush controller: stall mask, exception vs. mispredict redirect, held flush pulse.
// Optional CTRL_PERF_CNT_EN adds stall-cycle and flush-by-cause performance counters.
module pipe_flush_ctrl #(
    parameter int NSTAGE     = 4,
    parameter int ADDR_W     = 32,
    parameter int FLUSH_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    pipe_flush_ctrl_if.slave bus,
    output logic [1:0]       state_dbg
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_br_flush,
    output logic [31:0]      perf_exc_flush
`endif
);
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic              flush_q, flush_d;
    logic              cause_q, cause_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] exc_pc;
    logic [ADDR_W-1:0] br_src;
    logic [NSTAGE-1:0] req_mask;
    logic              no_req;
    logic              start_exc, start_br;

    // Stage k stalling must also hold every younger stage below it: prefix-OR from the top.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        req_mask = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc         = acc | bus.stallreq[i];
            req_mask[i] = acc;
        end
    end

    assign no_req    = (bus.stallreq == '0);
    assign bus.stall = (rst || bus.exception_flag || state_q == ST_FLUSH) ? '0 : req_mask;

    always_comb begin
        case (bus.exception_type)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
            EXC_BP, EXC_RI, EXC_OV, EXC_TR: exc_pc = bus.ebase_i;
            EXC_ERET:                       exc_pc = bus.cp0_epc_i;
            default:                        exc_pc = '0;
        endcase
    end

    // br_mispredict is a one-cycle valid strobe qualifying br_target; there is no ready,
    // so a mispredict that cannot flush yet is captured into tgt_q instead of back-pressured.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        flush_d   = flush_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        tgt_d     = tgt_q;
        start_exc = 1'b0;
        start_br  = 1'b0;
        br_src    = (state_q == ST_PEND) ? tgt_q : bus.br_target;

        case (state_q)
            ST_RUN: begin
                if (bus.exception_flag) begin
                    start_exc = 1'b1;
                end else if (bus.br_mispredict) begin
                    if (no_req) begin
                        start_br = 1'b1;
                    end else begin
                        tgt_d   = bus.br_target;
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (bus.exception_flag) begin
                    start_exc = 1'b1;
                end else if (no_req) begin
                    start_br = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (bus.exception_flag) begin
                    start_exc = 1'b1;
                end else if (hold_q <= 4'd1) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (start_exc) begin
            state_d = ST_FLUSH;
            flush_d = 1'b1;
            hold_d  = HOLD_INIT;
            cause_d = 1'b0;
            epc_d   = exc_pc;
            tgt_d   = '0;
        end else if (start_br) begin
            state_d = ST_FLUSH;
            flush_d = 1'b1;
            hold_d  = HOLD_INIT;
            cause_d = 1'b1;
            epc_d   = br_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            hold_q  <= 4'd0;
            flush_q <= 1'b0;
            cause_q <= 1'b0;
            epc_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            flush_q <= flush_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus.flush            = flush_q;
    assign bus.flush_cause      = cause_q;
    assign bus.epc_o            = epc_q;
    assign bus.flush_to_ibuffer = rst | flush_q;
    assign bus.br_pending       = (state_q == ST_PEND);
    assign state_dbg            = state_q;

`ifdef CTRL_PERF_CNT_EN
    // Only entries from RUN/PEND count; an exception restarting a hold is not a new entry.
    logic flush_entry;
    assign flush_entry = (start_exc || start_br) && (state_q != ST_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_br_flush     <= 32'd0;
            perf_exc_flush    <= 32'd0;
        end else begin
            if (bus.stall != '0) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush_entry && start_br) perf_br_flush <= perf_br_flush + 32'd1;
            if (flush_entry && start_exc) perf_exc_flush <= perf_exc_flush + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed + randomized bench for pipe_flush_ctrl with FLUSH_HOLD=3, checked
// against a cycle-level behavioural model of the redirect rules.
module tb_pipe_flush_ctrl;
    localparam int NSTAGE = 4;
    localparam int ADDR_W = 32;
    localparam int HOLD   = 3;
    localparam int W      = 36;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_br_flush, perf_exc_flush;
`endif

    pipe_flush_ctrl_if #(.NSTAGE(NSTAGE), .ADDR_W(ADDR_W)) bus ();

    pipe_flush_ctrl #(.NSTAGE(NSTAGE), .ADDR_W(ADDR_W), .FLUSH_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef CTRL_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_br_flush     (perf_br_flush),
        .perf_exc_flush    (perf_exc_flush)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int total = 0;
    int bad   = 0;
    int step_no = 0;
    logic [W-1:0] exp_q[$];

    int                m_left;   // flush cycles still to be shown after the next edge
    bit                m_pend;
    logic [ADDR_W-1:0] m_tgt;
    logic              m_cause;
    logic [ADDR_W-1:0] m_epc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_stall(logic [3:0] sr, logic exc, bit flushing);
        int h;
        h = -1;
        for (int i = 0; i < NSTAGE; i++) if (sr[i]) h = i;
        if (exc || flushing || h < 0) return 4'd0;
        return 4'((1 << (h + 1)) - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] model_exc_pc(logic [4:0] et, logic [ADDR_W-1:0] epc,
                                                       logic [ADDR_W-1:0] eb);
        if (et inside {EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_TR})
            return eb;
        if (et == EXC_ERET) return epc;
        return '0;
    endfunction

    task automatic model_clear();
        m_left  = 0;
        m_pend  = 0;
        m_tgt   = '0;
        m_cause = 1'b0;
        m_epc   = '0;
    endtask

    task automatic model_start(input logic cause, input logic [ADDR_W-1:0] pc);
        m_left  = HOLD;
        m_cause = cause;
        m_epc   = pc;
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drive one cycle of inputs, check stall, advance model, check registers.
    task automatic step(input logic [3:0] sr, input logic br, input logic [31:0] bt,
                        input logic exc, input logic [4:0] et,
                        input logic [31:0] epc, input logic [31:0] eb);
        logic [ADDR_W-1:0] xpc;
        logic [W-1:0]      exp;
        logic [W-1:0]      obs;
        step_no++;
        bus.stallreq       = sr;
        bus.br_mispredict  = br;
        bus.br_target      = bt;
        bus.exception_flag = exc;
        bus.exception_type = et;
        bus.cp0_epc_i      = epc;
        bus.ebase_i        = eb;
        #2;
        chk("stall", 64'(bus.stall), 64'(model_stall(sr, exc, m_left > 0)));

        xpc = model_exc_pc(et, epc, eb);
        if (m_left > 0) begin
            if (exc) model_start(1'b0, xpc);
            else m_left--;
        end else if (m_pend) begin
            if (exc) begin
                m_pend = 0;
                model_start(1'b0, xpc);
            end else if (sr == 4'd0) begin
                m_pend = 0;
                model_start(1'b1, m_tgt);
            end
        end else if (exc) begin
            model_start(1'b0, xpc);
        end else if (br) begin
            if (sr == 4'd0) model_start(1'b1, bt);
            else begin
                m_pend = 1;
                m_tgt  = bt;
            end
        end
        exp_q.push_back({m_left > 0, m_left > 0, m_cause, m_pend, m_epc});

        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        obs = {bus.flush_to_ibuffer, bus.flush, bus.flush_cause, bus.br_pending, bus.epc_o};
        chk("regs{fti,flush,cause,pend,epc}", 64'(obs), 64'(exp));
    endtask

    task automatic idle(input int n, input logic [3:0] sr);
        for (int i = 0; i < n; i++) step(sr, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 32'h0);
    endtask

    // Reset checks while rst is high; asserted at posedge+1 so it is truly asynchronous.
    task automatic reset_pulse();
        rst = 1'b1;
        bus.stallreq = 4'b0100;
        #1;
        chk("rst_flush", 64'(bus.flush), 64'd0);
        chk("rst_epc", 64'(bus.epc_o), 64'd0);
        chk("rst_pend", 64'(bus.br_pending), 64'd0);
        chk("rst_cause", 64'(bus.flush_cause), 64'd0);
        chk("rst_fti", 64'(bus.flush_to_ibuffer), 64'd1);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] codes[10];
        codes = '{EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_TR,
                  EXC_ERET, 5'h1f};
        rst = 1'b1;
        bus.stallreq = '0; bus.br_mispredict = 0; bus.br_target = '0;
        bus.exception_flag = 0; bus.exception_type = '0; bus.cp0_epc_i = '0; bus.ebase_i = '0;
        model_clear();
        @(posedge clk);
        #1;
        reset_pulse();

        // Stall mask shapes.
        idle(1, 4'b0100);
        idle(1, 4'b0010);
        idle(1, 4'b0001);
        idle(1, 4'b1010);

        // Mispredict with no stall: flush for HOLD cycles, then drop.
        step(4'b0000, 1'b1, 32'hBFC0_0100, 1'b0, 5'h0, 32'h0, 32'h0);
        idle(HOLD + 1, 4'b0000);

        // Mispredict under a deeper stall waits, a younger mispredict is ignored, then release.
        step(4'b0100, 1'b1, 32'h8000_0040, 1'b0, 5'h0, 32'h0, 32'h0);
        step(4'b0100, 1'b1, 32'h1234_5678, 1'b0, 5'h0, 32'h0, 32'h0);
        idle(1, 4'b0100);
        idle(HOLD + 2, 4'b0000);

        // Exception (ERET) together with mispredict and stall: exception wins.
        step(4'b0100, 1'b1, 32'hDEAD_0000, 1'b1, EXC_ERET, 32'h8000_1234, 32'hBFC0_0380);
        idle(HOLD + 1, 4'b0000);

        // Pending branch discarded by OV exception; no later branch flush.
        step(4'b0100, 1'b1, 32'h9000_0000, 1'b0, 5'h0, 32'h0, 32'h0);
        idle(1, 4'b0100);
        step(4'b0100, 1'b0, 32'h0, 1'b1, EXC_OV, 32'h0, 32'hBFC0_0380);
        idle(HOLD + 3, 4'b0000);

        // Unknown code redirects to 0; SYS during a hold restarts it.
        step(4'b0000, 1'b0, 32'h0, 1'b1, 5'h1f, 32'h1111_1111, 32'h2222_2222);
        idle(1, 4'b0000);
        step(4'b0000, 1'b1, 32'h7777_0000, 1'b1, EXC_SYS, 32'h0, 32'hBFC0_0200);
        idle(HOLD + 1, 4'b0000);

        // Reset mid-FLUSH and mid-PEND.
        step(4'b0000, 1'b1, 32'hA000_0000, 1'b0, 5'h0, 32'h0, 32'h0);
        idle(1, 4'b0000);
        reset_pulse();
        idle(2, 4'b0000);
        step(4'b0010, 1'b1, 32'hA000_0100, 1'b0, 5'h0, 32'h0, 32'h0);
        reset_pulse();
        idle(3, 4'b0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] sr;
            sr = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            step(sr, $urandom_range(0, 3) == 0, $urandom,
                 $urandom_range(0, 9) == 0, codes[$urandom_range(0, 9)], $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
